// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit: one shared 4-bit carry-lookahead slice,
// one nibble per clock (LSB first) with the ripple carry held in a register.

module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);
   assign s    = p ^ c[3:0];
   assign co   = c[4];
endmodule

module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Sub,
   input  logic             Cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);
   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [KW-1:0]    k;
   logic             carry;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_s;
   logic             nib_co;
   logic             last;

   // Operand-nibble select for the current index
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < N; i++) begin
         if (k == KW'(i)) begin
            nib_a = opa[4*i +: 4];
            nib_b = opb[4*i +: 4];
         end
      end
   end

   assign last = (k == KW'(N - 1));

   cla4 u_cla4 (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry),
      .s  (nib_s),
      .co (nib_co)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (Start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign Busy = (state == S_RUN);
   assign Done = (state == S_DONE);

   // Operand latch, carry chain and result assembly
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         opa      <= '0;
         opb      <= '0;
         carry    <= 1'b0;
         k        <= '0;
         Sum      <= '0;
         Cout     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  opa   <= A;
                  opb   <= Sub ? ~B : B;
                  carry <= Sub ? 1'b1 : Cin;
                  k     <= '0;
               end
            end
            S_RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (k == KW'(i)) Sum[4*i +: 4] <= nib_s;
               end
               carry <= nib_co;
               if (last) begin
                  Cout     <= nib_co;
                  Overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) && (nib_s[3] != opa[WIDTH-1]);
                  k        <= '0;
               end else begin
                  k <= k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed, back-to-back, async reset
// and randomized runs on WIDTH=16 and WIDTH=4 instances against an arithmetic model.

module tb_nibble_serial_adder;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;
   logic        start4, sub4, cin4, busy4, done4, cout4, ovf4;
   logic [3:0]  a4, b4, sum4;

   int checks = 0;
   int errors = 0;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .Clk(Clk), .Reset(Reset), .Start(start16), .Sub(sub16), .Cin(cin16),
      .A(a16), .B(b16), .Busy(busy16), .Done(done16), .Sum(sum16),
      .Cout(cout16), .Overflow(ovf16)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .Start(start4), .Sub(sub4), .Cin(cin4),
      .A(a4), .B(b4), .Busy(busy4), .Done(done4), .Sum(sum4),
      .Cout(cout4), .Overflow(ovf4)
   );

   // Arithmetic reference: unsigned result/carry and signed-range overflow
   function automatic void model(input int w, input longint a, input longint b,
                                 input bit sub, input bit cin,
                                 output longint s, output bit co, output bit ov);
      longint m, sa, sb, u, sr;
      m  = longint'(1) << w;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      if (sub) begin
         u  = a - b;
         co = (a >= b);
         sr = sa - sb;
      end else begin
         u  = a + b + longint'(cin);
         co = (u >= m);
         sr = sa + sb + longint'(cin);
      end
      s  = ((u % m) + m) % m;
      ov = (sr >= m / 2) || (sr < -(m / 2));
   endfunction

   // One WIDTH=16 transaction; observes the N+2 cycles following the accepting edge
   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, output logic [15:0] s, output logic co,
                        output logic ov, output int busy_n, output int done_n,
                        output int done_lat, output int overlap);
      @(negedge Clk);
      start16 = 1'b1; a16 = a; b16 = b; sub16 = sub; cin16 = cin;
      @(posedge Clk); #1;
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      sub16 = 1'($urandom); cin16 = 1'($urandom);
      busy_n = 0; done_n = 0; done_lat = -1; overlap = 0; s = '0; co = 1'b0; ov = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (j > 0) begin @(posedge Clk); #1; end
         if (busy16) busy_n++;
         if (busy16 && done16) overlap++;
         if (done16) begin
            done_n++;
            if (done_lat < 0) begin done_lat = j; s = sum16; co = cout16; ov = ovf16; end
         end
      end
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                       input logic cin, output logic [3:0] s, output logic co,
                       output logic ov, output int done_n, output int done_lat);
      @(negedge Clk);
      start4 = 1'b1; a4 = a; b4 = b; sub4 = sub; cin4 = cin;
      @(posedge Clk); #1;
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      done_n = 0; done_lat = -1; s = '0; co = 1'b0; ov = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) begin @(posedge Clk); #1; end
         if (done4) begin
            done_n++;
            if (done_lat < 0) begin done_lat = j; s = sum4; co = cout4; ov = ovf4; end
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy16); end
      checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done16); end
      checks++; if (sum16 !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum16); end
      checks++; if ({cout16, ovf16} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {cout16, ovf16}); end
      checks++; if ({busy4, done4, sum4} !== 6'h0) begin errors++; $display("FAIL reset_w4: got %h expected 00", {busy4, done4, sum4}); end
      @(negedge Clk); Reset = 1'b0;
   endtask

   typedef struct {
      logic [15:0] a, b;
      logic        sub, cin;
      logic [15:0] sum;
      logic        co, ov;
   } vec_t;

   task automatic test_directed();
      vec_t v[6];
      logic [15:0] s; logic co, ov; int bn, dn, dl, ol;
      v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      v[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      v[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      v[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run16(v[i].a, v[i].b, v[i].sub, v[i].cin, s, co, ov, bn, dn, dl, ol);
         checks++; if (s !== v[i].sum) begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", i, s, v[i].sum); end
         checks++; if (co !== v[i].co) begin errors++; $display("FAIL dir%0d_cout: got %b expected %b", i, co, v[i].co); end
         checks++; if (ov !== v[i].ov) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", i, ov, v[i].ov); end
         checks++; if (bn !== 4) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 4", i, bn); end
         checks++; if (dn !== 1 || dl !== 4) begin errors++; $display("FAIL dir%0d_done: got count %0d latency %0d expected 1 and 4", i, dn, dl); end
         checks++; if (ol !== 0) begin errors++; $display("FAIL dir%0d_busy_done_overlap: got %0d expected 0", i, ol); end
      end
   endtask

   task automatic test_back_to_back();
      logic [33:0] q[$];
      logic [33:0] op;
      longint es; bit eco, eov;
      for (int c = 0; c < 30; c++) begin
         @(negedge Clk);
         start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
         sub16 = 1'($urandom); cin16 = 1'($urandom);
         if (c % 6 == 0) q.push_back({sub16, cin16, a16, b16});
         @(posedge Clk); #1;
         checks++; if (done16 !== (c % 6 == 4)) begin errors++; $display("FAIL b2b_done_c%0d: got %b expected %b", c, done16, c % 6 == 4); end
         checks++; if (busy16 !== (c % 6 < 4)) begin errors++; $display("FAIL b2b_busy_c%0d: got %b expected %b", c, busy16, c % 6 < 4); end
         if (c % 6 == 4 && q.size() > 0) begin
            op = q.pop_front();
            model(16, longint'(op[31:16]), longint'(op[15:0]), op[33], op[32], es, eco, eov);
            checks++;
            if ({sum16, cout16, ovf16} !== {16'(es), eco, eov}) begin
               errors++;
               $display("FAIL b2b_result_c%0d: got %h/%b/%b expected %h/%b/%b", c, sum16, cout16, ovf16, 16'(es), eco, eov);
            end
         end
      end
      @(negedge Clk); start16 = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] s; logic co, ov; int bn, dn, dl, ol, late;
      @(negedge Clk);
      start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0;
      @(posedge Clk); #1; start16 = 1'b0;
      @(posedge Clk); @(posedge Clk);
      #2 Reset = 1'b1;
      #1;
      checks++; if ({busy16, done16} !== 2'b00) begin errors++; $display("FAIL rst_mid_busy_done: got %b expected 00", {busy16, done16}); end
      checks++; if (sum16 !== 16'h0) begin errors++; $display("FAIL rst_mid_sum: got %h expected 0000", sum16); end
      checks++; if ({cout16, ovf16} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00", {cout16, ovf16}); end
      @(posedge Clk); @(negedge Clk); Reset = 1'b0;
      late = 0;
      for (int j = 0; j < 6; j++) begin
         @(posedge Clk); #1;
         if (done16 || busy16) late++;
      end
      checks++; if (late !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", late); end
      run16(16'h1111, 16'h2222, 1'b0, 1'b1, s, co, ov, bn, dn, dl, ol);
      checks++; if ({s, co, ov} !== {16'h3334, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_mid_restart: got %h/%b/%b expected 3334/0/0", s, co, ov); end
      checks++; if (dn !== 1 || dl !== 4) begin errors++; $display("FAIL rst_mid_restart_done: got count %0d latency %0d expected 1 and 4", dn, dl); end
   endtask

   task automatic test_random16();
      logic [15:0] a, b, s; logic sub, cin, co, ov; int bn, dn, dl, ol;
      longint es; bit eco, eov;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         if (i % 10 == 0) b = (i % 20 == 0) ? 16'hFFFF : 16'h8000;
         model(16, longint'(a), longint'(b), sub, cin, es, eco, eov);
         run16(a, b, sub, cin, s, co, ov, bn, dn, dl, ol);
         checks++;
         if ({s, co, ov} !== {16'(es), eco, eov}) begin
            errors++;
            $display("FAIL rnd16_%0d: a=%h b=%h sub=%b cin=%b got %h/%b/%b expected %h/%b/%b", i, a, b, sub, cin, s, co, ov, 16'(es), eco, eov);
         end
         checks++; if (dn !== 1 || dl !== 4 || bn !== 4) begin errors++; $display("FAIL rnd16_%0d_timing: got done %0d lat %0d busy %0d expected 1 4 4", i, dn, dl, bn); end
      end
   endtask

   task automatic test_random4();
      logic [3:0] a, b, s; logic sub, cin, co, ov; int dn, dl;
      longint es; bit eco, eov;
      for (int i = 0; i < 500; i++) begin
         a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         model(4, longint'(a), longint'(b), sub, cin, es, eco, eov);
         run4(a, b, sub, cin, s, co, ov, dn, dl);
         checks++;
         if ({s, co, ov} !== {4'(es), eco, eov}) begin
            errors++;
            $display("FAIL rnd4_%0d: a=%h b=%h sub=%b cin=%b got %h/%b/%b expected %h/%b/%b", i, a, b, sub, cin, s, co, ov, 4'(es), eco, eov);
         end
         checks++; if (dn !== 1 || dl !== 1) begin errors++; $display("FAIL rnd4_%0d_timing: got done %0d lat %0d expected 1 1", i, dn, dl); end
      end
   endtask

   initial begin
      start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
      start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_run();
      test_random16();
      test_random4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
